// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   DATA_W   : write data width
//   REG_AW   : register address width
//   REG_ZERO : hard-wired zero register, never actually written
//   wb_req_t : one writeback request {destination, data, byte-op flag}
package regfile_wb_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              byte_op;
    } wb_req_t;

    // A request aimed at $0 is consumed but must never reach the register file.
    function automatic logic writes_reg(input wb_req_t req);
        return (req.rd != REG_ZERO);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two requesters (ALU, MEM), the arbiter and the
// register_block write port.
//   alu_* / mem_*  : valid/ready request channels with {reg, data, byte}
//   regWrite, write_reg, write_data, byteOperations : register_block write port
//   busy           : at least one holding slot is occupied
// modport slave is the arbiter side, modport master the requester/observer side.
interface regfile_wb_arbiter_if;

    logic                                     alu_valid;
    logic                                     alu_ready;
    logic [regfile_wb_arbiter_pkg::REG_AW-1:0] alu_reg;
    logic [regfile_wb_arbiter_pkg::DATA_W-1:0] alu_data;
    logic                                     alu_byte;

    logic                                     mem_valid;
    logic                                     mem_ready;
    logic [regfile_wb_arbiter_pkg::REG_AW-1:0] mem_reg;
    logic [regfile_wb_arbiter_pkg::DATA_W-1:0] mem_data;
    logic                                     mem_byte;

    logic                                     regWrite;
    logic [regfile_wb_arbiter_pkg::REG_AW-1:0] write_reg;
    logic [regfile_wb_arbiter_pkg::DATA_W-1:0] write_data;
    logic                                     byteOperations;
    logic                                     busy;

    modport slave (
        input  alu_valid, alu_reg, alu_data, alu_byte,
        input  mem_valid, mem_reg, mem_data, mem_byte,
        output alu_ready, mem_ready,
        output regWrite, write_reg, write_data, byteOperations, busy
    );

    modport master (
        output alu_valid, alu_reg, alu_data, alu_byte,
        output mem_valid, mem_reg, mem_data, mem_byte,
        input  alu_ready, mem_ready,
        input  regWrite, write_reg, write_data, byteOperations, busy
    );

endinterface

// File: rtl/regfile_wb_arbiter_slot.sv
// One-entry writeback holding slot with valid/ready handshake.
//   clk, reset : clock, asynchronous active-high reset
//   in_valid   : requester offers in_req
//   in_req     : request payload
//   grant      : arbiter consumes the held entry this cycle
//   ready      : slot accepts this cycle (empty, or being drained)
//   full       : slot holds a request
//   q          : held request
module regfile_wb_arbiter_slot
    import regfile_wb_arbiter_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    in_valid,
    input  wb_req_t in_req,
    input  logic    grant,
    output logic    ready,
    output logic    full,
    output wb_req_t q
);

    logic    full_r;
    wb_req_t q_r;

    // A granted slot drains on this edge, so it can take a new entry at the same time.
    assign ready = ~reset & (~full_r | grant);
    assign full  = full_r;
    assign q     = q_r;

    // Slot occupancy and payload capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_r <= 1'b0;
            q_r    <= '0;
        end else if (in_valid && ready) begin
            full_r <= 1'b1;
            q_r    <= in_req;
        end else if (grant) begin
            full_r <= 1'b0;
            q_r    <= q_r;
        end else begin
            full_r <= full_r;
            q_r    <= q_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register_block write port between the ALU result path
// and the memory-load path. MEM normally wins; an ALU entry that has lost
// STARVE_LIMIT times in a row is forced through, unless both target the same
// nonzero register (MEM first keeps program order, ALU value lands last).
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester channels and register_block write port (slave side)
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    wb_req_t           alu_in_s;
    wb_req_t           mem_in_s;
    wb_req_t           alu_q_s;
    wb_req_t           mem_q_s;
    wb_req_t           win_s;
    logic              alu_full_s;
    logic              mem_full_s;
    logic              alu_ready_s;
    logic              mem_ready_s;
    logic              grant_alu_s;
    logic              grant_mem_s;
    logic              same_dest_s;
    logic [3:0]        starve_cnt_r;
    logic              reg_write_r;
    logic [REG_AW-1:0] write_reg_r;
    logic [DATA_W-1:0] write_data_r;
    logic              byte_op_r;

    assign alu_in_s = '{rd: bus.alu_reg, data: bus.alu_data, byte_op: bus.alu_byte};
    assign mem_in_s = '{rd: bus.mem_reg, data: bus.mem_data, byte_op: bus.mem_byte};

    regfile_wb_arbiter_slot u_alu_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.alu_valid),
        .in_req   (alu_in_s),
        .grant    (grant_alu_s),
        .ready    (alu_ready_s),
        .full     (alu_full_s),
        .q        (alu_q_s)
    );

    regfile_wb_arbiter_slot u_mem_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.mem_valid),
        .in_req   (mem_in_s),
        .grant    (grant_mem_s),
        .ready    (mem_ready_s),
        .full     (mem_full_s),
        .q        (mem_q_s)
    );

    // Grant selection among full slots.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_mem_s = 1'b0;
        same_dest_s = (alu_q_s.rd == mem_q_s.rd) && (alu_q_s.rd != REG_ZERO);
        if (alu_full_s && mem_full_s) begin
            if (same_dest_s) begin
                grant_mem_s = 1'b1;
            end else if (starve_cnt_r == STARVE_MAX) begin
                grant_alu_s = 1'b1;
            end else begin
                grant_mem_s = 1'b1;
            end
        end else if (alu_full_s) begin
            grant_alu_s = 1'b1;
        end else if (mem_full_s) begin
            grant_mem_s = 1'b1;
        end else begin
            grant_alu_s = 1'b0;
            grant_mem_s = 1'b0;
        end
        win_s = grant_alu_s ? alu_q_s : mem_q_s;
    end

    // Count consecutive lost cycles of a waiting ALU entry, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (alu_full_s && !grant_alu_s) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= 4'd0;
        end
    end

    // Registered register_block write port; a $0 winner burns its cycle silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= '0;
            write_data_r <= '0;
            byte_op_r    <= 1'b0;
        end else if ((grant_alu_s || grant_mem_s) && writes_reg(win_s)) begin
            reg_write_r  <= 1'b1;
            write_reg_r  <= win_s.rd;
            write_data_r <= win_s.data;
            byte_op_r    <= win_s.byte_op;
        end else begin
            reg_write_r  <= 1'b0;
            write_reg_r  <= write_reg_r;
            write_data_r <= write_data_r;
            byte_op_r    <= byte_op_r;
        end
    end

    assign bus.alu_ready      = alu_ready_s;
    assign bus.mem_ready      = mem_ready_s;
    assign bus.regWrite       = reg_write_r;
    assign bus.write_reg      = write_reg_r;
    assign bus.write_data     = write_data_r;
    assign bus.byteOperations = byte_op_r;
    assign bus.busy           = alu_full_s | mem_full_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_LIMIT = 3).
module tb_regfile_wb_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its expected value.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d, input logic b);
        bus.alu_valid = v;
        bus.alu_reg   = r;
        bus.alu_data  = d;
        bus.alu_byte  = b;
    endtask

    task automatic drive_mem(input logic v, input logic [4:0] r, input logic [31:0] d, input logic b);
        bus.mem_valid = v;
        bus.mem_reg   = r;
        bus.mem_data  = d;
        bus.mem_byte  = b;
    endtask

    // Expect a write strobe of reg/data/byte on the current cycle.
    task automatic expect_write(input string tag, input logic [4:0] r, input logic [31:0] d, input logic b);
        check_eq({tag, "_regWrite"}, {31'd0, bus.regWrite}, 32'd1);
        check_eq({tag, "_write_reg"}, {27'd0, bus.write_reg}, {27'd0, r});
        check_eq({tag, "_write_data"}, bus.write_data, d);
        check_eq({tag, "_byteOps"}, {31'd0, bus.byteOperations}, {31'd0, b});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        drive_mem(1'b0, 5'd0, 32'd0, 1'b0);
        #3;
        check_eq("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        check_eq("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        #9;
        reset = 1'b0;
        #1;
        check_eq("rst_regWrite", {31'd0, bus.regWrite}, 32'd0);
        check_eq("rst_write_reg", {27'd0, bus.write_reg}, 32'd0);
        check_eq("rst_write_data", bus.write_data, 32'd0);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rel_alu_ready", {31'd0, bus.alu_ready}, 32'd1);

        // 1: single ALU write, one-cycle latency after capture
        drive_alu(1'b1, 5'd3, 32'h1234_5678, 1'b0);
        step();
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("t1_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("t1_no_write_yet", {31'd0, bus.regWrite}, 32'd0);
        step();
        expect_write("t1", 5'd3, 32'h1234_5678, 1'b0);
        check_eq("t1_busy_done", {31'd0, bus.busy}, 32'd0);
        step();
        check_eq("t1_strobe_drop", {31'd0, bus.regWrite}, 32'd0);
        check_eq("t1_reg_hold", {27'd0, bus.write_reg}, 32'd3);

        // 2: simultaneous requests, MEM first then ALU
        drive_alu(1'b1, 5'd4, 32'hA5A5_A5A5, 1'b0);
        drive_mem(1'b1, 5'd5, 32'h0000_00FF, 1'b1);
        step();
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        drive_mem(1'b0, 5'd0, 32'd0, 1'b0);
        step();
        expect_write("t2_mem", 5'd5, 32'h0000_00FF, 1'b1);
        check_eq("t2_busy", {31'd0, bus.busy}, 32'd1);
        step();
        expect_write("t2_alu", 5'd4, 32'hA5A5_A5A5, 1'b0);
        step();
        check_eq("t2_idle", {31'd0, bus.regWrite}, 32'd0);

        // 3: MEM streams continuously; ALU loses 3 times then is forced through
        drive_alu(1'b1, 5'd9, 32'h0000_0099, 1'b0);
        drive_mem(1'b1, 5'd10, 32'h1000_000A, 1'b0);
        step();
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive_mem(1'b1, 5'(11 + i), 32'h1000_0000 + 32'(11 + i), 1'b0);
            step();
            expect_write($sformatf("t3_mem%0d", i), 5'(10 + i), 32'h1000_0000 + 32'(10 + i), 1'b0);
        end
        check_eq("t3_starve_sat", {28'd0, dut.starve_cnt_r}, 32'd3);
        check_eq("t3_mem_blocked", {31'd0, bus.mem_ready}, 32'd0);
        check_eq("t3_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        step();
        expect_write("t3_alu", 5'd9, 32'h0000_0099, 1'b0);
        check_eq("t3_starve_clr", {28'd0, dut.starve_cnt_r}, 32'd0);
        drive_mem(1'b0, 5'd0, 32'd0, 1'b0);
        step();
        expect_write("t3_mem_last", 5'd13, 32'h1000_000D, 1'b0);
        step();
        check_eq("t3_idle", {31'd0, bus.regWrite}, 32'd0);

        // 4: same destination with saturated counter keeps MEM-then-ALU order
        drive_alu(1'b1, 5'd7, 32'h0000_00A1, 1'b0);
        drive_mem(1'b1, 5'd21, 32'h0000_00B1, 1'b0);
        step();
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        drive_mem(1'b1, 5'd22, 32'h0000_00B2, 1'b0);
        step();
        drive_mem(1'b1, 5'd23, 32'h0000_00B3, 1'b0);
        step();
        drive_mem(1'b1, 5'd7, 32'h0000_00B7, 1'b0);
        step();
        expect_write("t4_mem23", 5'd23, 32'h0000_00B3, 1'b0);
        drive_mem(1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("t4_alu_held", {31'd0, bus.alu_ready}, 32'd0);
        step();
        expect_write("t4_mem7", 5'd7, 32'h0000_00B7, 1'b0);
        check_eq("t4_starve_hold", {28'd0, dut.starve_cnt_r}, 32'd3);
        step();
        expect_write("t4_alu7", 5'd7, 32'h0000_00A1, 1'b0);
        step();
        check_eq("t4_idle", {31'd0, bus.regWrite}, 32'd0);

        // 5: $0 request is consumed without a write strobe
        drive_alu(1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1);
        step();
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        check_eq("t5_busy", {31'd0, bus.busy}, 32'd1);
        check_eq("t5_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        step();
        check_eq("t5_no_write", {31'd0, bus.regWrite}, 32'd0);
        check_eq("t5_busy_clr", {31'd0, bus.busy}, 32'd0);
        check_eq("t5_reg_hold", {27'd0, bus.write_reg}, 32'd7);
        check_eq("t5_data_hold", bus.write_data, 32'h0000_00A1);
        step();
        check_eq("t5_no_write2", {31'd0, bus.regWrite}, 32'd0);

        // 6: asynchronous reset with both slots full and a write in flight
        drive_alu(1'b1, 5'd12, 32'hC0C0_C0C0, 1'b0);
        drive_mem(1'b1, 5'd13, 32'hD0D0_D0D0, 1'b0);
        step();
        drive_alu(1'b0, 5'd0, 32'd0, 1'b0);
        drive_mem(1'b1, 5'd14, 32'hE0E0_E0E0, 1'b0);
        step();
        drive_mem(1'b0, 5'd0, 32'd0, 1'b0);
        expect_write("t6_pre", 5'd13, 32'hD0D0_D0D0, 1'b0);
        check_eq("t6_pre_busy", {31'd0, bus.busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("t6_regWrite", {31'd0, bus.regWrite}, 32'd0);
        check_eq("t6_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("t6_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        check_eq("t6_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("t6_no_stale%0d", i), {31'd0, bus.regWrite}, 32'd0);
            check_eq($sformatf("t6_idle%0d", i), {31'd0, bus.busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
